// File: rtl/counter_event_monitor.sv
// rtl/counter_event_monitor.sv - samples counter values and queues threshold/wrap/direction events
module counter_event_monitor #(
    parameter int WIDTH      = 64,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                            clock0,
    input  logic                            reset,
    input  logic [WIDTH-1:0]                count_in,
    input  logic                            count_valid,
    input  logic                            thr_wr,
    input  logic [WIDTH-1:0]                thr_hi_in,
    input  logic [WIDTH-1:0]                thr_lo_in,
    output logic                            evt_valid,
    input  logic                            evt_ready,
    output logic [2:0]                      evt_code,
    output logic [WIDTH-1:0]                evt_count,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_level,
    output logic                            overflow,
    input  logic                            clear_overflow
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam logic [WIDTH-1:0] ALL_ONES = '1;
    localparam logic [LW-1:0] FULL_LEVEL = LW'(FIFO_DEPTH);

    localparam logic [2:0] CODE_HI   = 3'd1;
    localparam logic [2:0] CODE_LO   = 3'd2;
    localparam logic [2:0] CODE_WUP  = 3'd3;
    localparam logic [2:0] CODE_WDN  = 3'd4;
    localparam logic [2:0] CODE_DIR  = 3'd5;

    typedef enum logic [1:0] {
        DIR_UNKNOWN = 2'd0,
        DIR_UP      = 2'd1,
        DIR_DOWN    = 2'd2
    } dir_t;

    dir_t             dir_state, dir_next;
    logic [WIDTH-1:0] thr_hi, thr_lo;
    logic [WIDTH-1:0] prev_count;
    logic             prev_ok;

    logic             detect, wrap_up, wrap_down, step_up, step_down;
    logic             hi_hit, lo_hit, dir_change;
    logic             evt_fire;
    logic [2:0]       new_code;

    logic [2:0]       mem_code  [FIFO_DEPTH];
    logic [WIDTH-1:0] mem_count [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [LW-1:0]    level;
    logic             pop, push_ok, drop, full;

    assign detect    = count_valid && prev_ok;
    assign wrap_up   = (prev_count == ALL_ONES) && (count_in == '0);
    assign wrap_down = (prev_count == '0) && (count_in == ALL_ONES);
    // Wraps override the raw magnitude compare so they read as continuing motion.
    assign step_up   = wrap_up   || (!wrap_down && (count_in > prev_count));
    assign step_down = wrap_down || (!wrap_up   && (count_in < prev_count));
    assign hi_hit    = (count_in == thr_hi) && (prev_count != thr_hi);
    assign lo_hit    = (count_in == thr_lo) && (prev_count != thr_lo);

    always_comb begin
        dir_next   = dir_state;
        dir_change = 1'b0;
        if (detect) begin
            case (dir_state)
                DIR_UNKNOWN: begin
                    if (step_up)        dir_next = DIR_UP;
                    else if (step_down) dir_next = DIR_DOWN;
                end
                DIR_UP: begin
                    if (step_down) begin
                        dir_next   = DIR_DOWN;
                        dir_change = 1'b1;
                    end
                end
                DIR_DOWN: begin
                    if (step_up) begin
                        dir_next   = DIR_UP;
                        dir_change = 1'b1;
                    end
                end
                default: dir_next = DIR_UNKNOWN;
            endcase
        end
    end

    always_comb begin
        evt_fire = 1'b0;
        new_code = 3'd0;
        if (detect) begin
            evt_fire = 1'b1;
            if (wrap_up)         new_code = CODE_WUP;
            else if (wrap_down)  new_code = CODE_WDN;
            else if (hi_hit)     new_code = CODE_HI;
            else if (lo_hit)     new_code = CODE_LO;
            else if (dir_change) new_code = CODE_DIR;
            else                 evt_fire = 1'b0;
        end
    end

    assign full    = (level == FULL_LEVEL);
    assign pop     = evt_valid && evt_ready;
    assign push_ok = evt_fire && (!full || pop);
    assign drop    = evt_fire && full && !pop;

    always_ff @(posedge clock0 or negedge reset) begin
        if (!reset) begin
            dir_state  <= DIR_UNKNOWN;
            thr_hi     <= ALL_ONES;
            thr_lo     <= '0;
            prev_count <= '0;
            prev_ok    <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level      <= '0;
            overflow   <= 1'b0;
        end else begin
            dir_state <= dir_next;
            if (thr_wr) begin
                thr_hi <= thr_hi_in;
                thr_lo <= thr_lo_in;
            end
            if (count_valid) begin
                prev_count <= count_in;
                prev_ok    <= 1'b1;
            end
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop)     rd_ptr <= rd_ptr + AW'(1);
            if (push_ok && !pop)      level <= level + LW'(1);
            else if (pop && !push_ok) level <= level - LW'(1);
            if (drop)                 overflow <= 1'b1;
            else if (clear_overflow)  overflow <= 1'b0;
        end
    end

    // Payload storage needs no reset: reads are masked whenever the FIFO is empty.
    always_ff @(posedge clock0) begin
        if (push_ok) begin
            mem_code[wr_ptr]  <= new_code;
            mem_count[wr_ptr] <= count_in;
        end
    end

    assign evt_valid  = (level != '0);
    assign fifo_level = level;
    assign evt_code   = evt_valid ? mem_code[rd_ptr]  : 3'd0;
    assign evt_count  = evt_valid ? mem_count[rd_ptr] : '0;
endmodule

// File: doc/counter_event_monitor.md
Name: counter_event_monitor

Overview:
Downstream consumer of the up/down counter's count output. It samples the count, detects threshold crossings, wrap-around and direction reversals, and queues one tagged event per sample. Events sit in a small FIFO and are drained over a valid/ready interface by the interrupt/trace logic. It sits directly on counter_output, using the counter's clock.

Parameters:
WIDTH, 64, width of the sampled count and of the thresholds.
FIFO_DEPTH, 4, number of event entries; power of two, 2 or more.

Ports:
clock0  input  1  sole clock, rising edge.
reset  input  1  asynchronous, active-low reset (asserted at 0).
count_in  input  WIDTH  count value from the up/down counter.
count_valid  input  1  sample count_in this cycle.
thr_wr  input  1  load thr_hi_in and thr_lo_in.
thr_hi_in  input  WIDTH  new high threshold.
thr_lo_in  input  WIDTH  new low threshold.
evt_valid  output  1  FIFO head holds an event.
evt_ready  input  1  consumer accepts the head event.
evt_code  output  3  head event code.
evt_count  output  WIDTH  count_in value that raised the head event.
fifo_level  output  clog2(FIFO_DEPTH)+1  number of entries held.
overflow  output  1  sticky flag: an event was dropped.
clear_overflow  input  1  clears overflow.

Behaviour:
- Reset (reset=0, async): prev_count=0, prev_ok=0, dir_state=UNKNOWN, thr_hi=all-ones, thr_lo=0, FIFO empty.
- Outputs during reset: evt_valid=0, evt_code=0, evt_count=0, fifo_level=0, overflow=0.
- Threshold write: thr_wr updates both thresholds at the clock edge. When thr_wr and count_valid are high in the same cycle, the compare uses the old thresholds.
- Sample: when count_valid=1, register prev_count<=count_in and prev_ok<=1. Samples with count_valid=0 are ignored completely.
- Event detection runs only when count_valid=1 and prev_ok=1. The first sample after reset raises no event.
- WRAP_UP (3'd3): prev=all-ones and cur=0.
- WRAP_DOWN (3'd4): prev=0 and cur=all-ones.
- HI_MATCH (3'd1): cur==thr_hi and prev!=thr_hi. Fires on entry only.
- LO_MATCH (3'd2): cur==thr_lo and prev!=thr_lo. Fires on entry only.
- DIR_CHANGE (3'd5): dir_state moves between UP and DOWN.
- Direction of a sample, unsigned compare: cur>prev or WRAP_UP means up; cur<prev or WRAP_DOWN means down; cur==prev leaves dir_state unchanged.
- dir_state FSM: UNKNOWN -> UP or DOWN on the first differing sample, with no event. UP <-> DOWN raises DIR_CHANGE.
- Several conditions in one sample: push only the highest-priority event, in the order WRAP_UP/WRAP_DOWN > HI_MATCH > LO_MATCH > DIR_CHANGE. Suppressed lower-priority events are not overflow. dir_state still updates.
- FIFO is show-ahead. An event pushed at edge N appears on evt_valid/evt_code/evt_count after edge N, so latency is 1 cycle from the sample.
- evt_valid = (fifo_level != 0). Pop occurs when evt_valid && evt_ready.
- evt_code and evt_count are 0 when the FIFO is empty. They stay stable while evt_valid=1 and evt_ready=0.
- Full FIFO with push and no pop: drop the event and set overflow.
- Full FIFO with push and pop in the same cycle: accept the push; level unchanged; no overflow.
- Empty FIFO with push and evt_ready=1: no pop; the event appears the next cycle.
- overflow: clear_overflow clears it. If a drop and clear_overflow occur in the same cycle, overflow stays set (set wins).
- Reset asserted mid-operation: FIFO, flags and direction state are discarded immediately. The first sample after release is again reference-only.

Test Plan:
- Reset, then samples 5, 6, 7 with evt_ready=1 -> no events (first sample is reference only, UNKNOWN->UP is silent); evt_valid stays 0.
- thr_hi=10; samples 9, 10, 10, 11 -> exactly one HI_MATCH with evt_count=10, valid one cycle after the 10 sample; the repeated 10 raises nothing.
- Samples 0xFFFF_FFFF_FFFF_FFFF, 0 -> WRAP_UP with evt_count=0. Then 0, 0xFFFF_FFFF_FFFF_FFFF -> DIR_CHANGE is suppressed and WRAP_DOWN is pushed.
- Samples 3, 4, 5, 4 -> DIR_CHANGE(5) with evt_count=4. With thr_lo=4 also set, only LO_MATCH is pushed at the 4 sample.
- evt_ready=0 and 5 events generated -> fifo_level=4, overflow=1, head is still event 1. clear_overflow -> overflow=0. Then drain -> 4 events in order.
- FIFO full with push and pop in the same cycle -> level stays 4, no overflow. Assert reset mid-burst -> evt_valid=0 and fifo_level=0 immediately.
